// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
// State encodings and control-vector field positions.
package pipe_ctrl_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam int CTL_W      = 5;
  localparam int CTL_PCW    = 4;
  localparam int CTL_IFW    = 3;
  localparam int CTL_FLUSH  = 2;
  localparam int CTL_BUBBLE = 1;
  localparam int CTL_HOLD   = 0;

  typedef logic [CTL_W-1:0] ctl_t;

  localparam ctl_t CTL_OFF    = 5'b00000;
  localparam ctl_t CTL_NORMAL = 5'b11000;
  localparam ctl_t CTL_FREEZE = 5'b00001;
  localparam ctl_t CTL_BRANCH = 5'b10110;
  localparam ctl_t CTL_LU     = 5'b00010;

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Load-use compare between the load in EX and the
// instruction in ID; r0 never creates a dependency.
module lu_detect #(
  parameter int REG_W = 5
) (
  input  logic             memread,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rt,
  output logic             lu
);

  logic rd_nz;
  logic hit_rs;
  logic hit_rt;

  assign rd_nz  = (rd != '0);
  assign hit_rs = (rd == rs);
  assign hit_rt = uses_rt & (rd == rt);
  assign lu     = memread & rd_nz & (hit_rs | hit_rt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, memory-wait
// freeze, branch squash, stall stats and watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int WDOG_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pcwrite_o,
  output logic             ifidwrite_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_hold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             wdog_err_o
);

  localparam int WCNT_W = $clog2(WDOG_MAX + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX =
    WCNT_W'(WDOG_MAX);

  state_e            state_q;
  state_e            state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              wdog_q;
  logic              wdog_d;
  logic [CNT_W-1:0]  stall_q;

  logic mw;
  logic lu;
  ctl_t run_ctl;
  ctl_t ctl;
  ctl_t ctl_out;

  assign mw = mem_req_i & ~mem_ack_i;

  lu_detect #(
    .REG_W(REG_W)
  ) u_lu (
    .memread(ex_memread_i),
    .rd     (ex_rd_i),
    .rs     (id_rs_i),
    .rt     (id_rt_i),
    .uses_rt(id_uses_rt_i),
    .lu     (lu)
  );

  always_comb begin
    run_ctl = CTL_NORMAL;
    unique case (1'b1)
      mw:                         run_ctl = CTL_FREEZE;
      !mw && branch_taken_i:      run_ctl = CTL_BRANCH;
      !mw && !branch_taken_i && lu:
                                  run_ctl = CTL_LU;
      default:                    run_ctl = CTL_NORMAL;
    endcase
  end

  always_comb begin
    ctl     = CTL_FREEZE;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      ST_RUN: begin
        ctl = run_ctl;
        if (mw) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        ctl = run_ctl;
        // a dropped request ends the wait like an ack
        if (!mw) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_MAX) begin
          state_d = ST_ERR;
          wdog_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_ERR: begin
        ctl = CTL_FREEZE;
      end
      default: begin
        ctl     = CTL_FREEZE;
        state_d = ST_RUN;
      end
    endcase
  end

  assign ctl_out = rst_i ? ctl : CTL_OFF;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wdog_q  <= wdog_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q <= '0;
    end else if (!ctl_out[CTL_PCW] &&
                 (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign pcwrite_o     = ctl_out[CTL_PCW];
  assign ifidwrite_o   = ctl_out[CTL_IFW];
  assign ifid_flush_o  = ctl_out[CTL_FLUSH];
  assign idex_bubble_o = ctl_out[CTL_BUBBLE];
  assign exmem_hold_o  = ctl_out[CTL_HOLD];
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_q;
  assign wdog_err_o    = wdog_q;

endmodule
